// File: rtl/instruction_cache_if.sv
// Fetch-side and L2-side signal bundle of the L1 instruction cache.
// The cache connects through the slave modport; the fetch stage/L2 environment uses master.
interface instruction_cache_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32,
  parameter int BLOCK_WIDTH   = 512,
  parameter int L2_ADDR_WIDTH = 26
);
  logic                     stall_instruction_cache;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     pc_valid;
  logic [WORD_WIDTH-1:0]    instruction;
  logic                     instruction_cache_ready;
  logic                     address_to_l2_ready_instruction_cache;
  logic                     address_to_l2_valid_instruction_cache;
  logic [L2_ADDR_WIDTH-1:0] address_to_l2_instruction_cache;
  logic                     data_from_l2_ready_instruction_cache;
  logic                     data_from_l2_valid_instruction_cache;
  logic [BLOCK_WIDTH-1:0]   data_from_l2_instruction_cache;

  modport slave (
    input  stall_instruction_cache, pc, pc_valid,
    input  address_to_l2_ready_instruction_cache,
    input  data_from_l2_valid_instruction_cache, data_from_l2_instruction_cache,
    output instruction, instruction_cache_ready,
    output address_to_l2_valid_instruction_cache, address_to_l2_instruction_cache,
    output data_from_l2_ready_instruction_cache
  );

  modport master (
    output stall_instruction_cache, pc, pc_valid,
    output address_to_l2_ready_instruction_cache,
    output data_from_l2_valid_instruction_cache, data_from_l2_instruction_cache,
    input  instruction, instruction_cache_ready,
    input  address_to_l2_valid_instruction_cache, address_to_l2_instruction_cache,
    input  data_from_l2_ready_instruction_cache
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only L1 instruction cache. Hits are served combinationally;
// a miss blocks until the whole line has been fetched from L2 as one block.
module instruction_cache #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORD_SIZE      = 4,
  parameter int WORD_PER_BLOCK = 16,
  parameter int CACHE_DEPTH    = 64
) (
  input  logic                clk,
  input  logic                rst,
  instruction_cache_if.slave  bus
);
  localparam int WORD_WIDTH  = 8 * WORD_SIZE;
  localparam int BLOCK_WIDTH = WORD_WIDTH * WORD_PER_BLOCK;
  localparam int BYTE_OFF_W  = $clog2(WORD_SIZE);
  localparam int WORD_OFF_W  = $clog2(WORD_PER_BLOCK);
  localparam int OFFSET_W    = BYTE_OFF_W + WORD_OFF_W;
  localparam int INDEX_W     = $clog2(CACHE_DEPTH);
  localparam int TAG_W       = ADDRESS_WIDTH - INDEX_W - OFFSET_W;
  localparam int BLK_ADDR_W  = ADDRESS_WIDTH - OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [CACHE_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]       tag_mem  [CACHE_DEPTH];
  logic [BLOCK_WIDTH-1:0] data_mem [CACHE_DEPTH];

  // Block address of the outstanding miss; the fill lands here even if PC moves on.
  logic [BLK_ADDR_W-1:0]  miss_blk_q;

  logic [TAG_W-1:0]       pc_tag;
  logic [INDEX_W-1:0]     pc_index;
  logic [WORD_OFF_W-1:0]  pc_word;
  logic [BLK_ADDR_W-1:0]  pc_blk;
  logic [INDEX_W-1:0]     miss_index;
  logic [TAG_W-1:0]       miss_tag;
  logic [BLOCK_WIDTH-1:0] line;
  logic [WORD_WIDTH-1:0]  word_sel;
  logic                   hit;
  logic                   ready;
  logic                   addr_valid;
  logic                   data_ready;
  logic                   start_miss;
  logic                   fill;

  assign pc_tag     = bus.pc[ADDRESS_WIDTH-1 -: TAG_W];
  assign pc_index   = bus.pc[OFFSET_W +: INDEX_W];
  assign pc_word    = bus.pc[BYTE_OFF_W +: WORD_OFF_W];
  assign pc_blk     = bus.pc[ADDRESS_WIDTH-1 -: BLK_ADDR_W];
  assign miss_index = miss_blk_q[INDEX_W-1:0];
  assign miss_tag   = miss_blk_q[BLK_ADDR_W-1 -: TAG_W];

  assign line = data_mem[pc_index];
  assign hit  = bus.pc_valid && valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

  // Pick the addressed word; word 0 sits in the most significant bits of the line.
  always_comb begin
    word_sel = '0;
    for (int w = 0; w < WORD_PER_BLOCK; w++) begin
      if (pc_word == WORD_OFF_W'(w)) begin
        word_sel = line[BLOCK_WIDTH-1-WORD_WIDTH*w -: WORD_WIDTH];
      end
    end
  end

  // Miss FSM next state and handshake strobes.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    addr_valid = 1'b0;
    data_ready = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = hit;
        if (bus.pc_valid && !hit && !bus.stall_instruction_cache) begin
          start_miss = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        addr_valid = 1'b1;
        data_ready = 1'b1;
        if (bus.address_to_l2_ready_instruction_cache) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        data_ready = 1'b1;
        if (bus.data_from_l2_valid_instruction_cache) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any miss in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Line valid bits; only these need clearing to empty the cache.
  always_ff @(posedge clk) begin
    if (rst)       valid_q <= '0;
    else if (fill) valid_q[miss_index] <= 1'b1;
  end

  // Capture the block address at the start of a miss.
  always_ff @(posedge clk) begin
    if (start_miss) miss_blk_q <= pc_blk;
  end

  // Tag and data arrays, written only by a fill.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[miss_index]  <= miss_tag;
      data_mem[miss_index] <= bus.data_from_l2_instruction_cache;
    end
  end

  assign bus.instruction_cache_ready               = ready;
  assign bus.instruction                           = ready ? word_sel : '0;
  assign bus.address_to_l2_valid_instruction_cache = addr_valid;
  assign bus.address_to_l2_instruction_cache       = addr_valid ? miss_blk_q : '0;
  assign bus.data_from_l2_ready_instruction_cache  = data_ready;
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: a behavioural L2 answers each address handshake with a
// block one cycle later; fetch vectors come from a table and expected words go through
// a scoreboard queue that is drained whenever the cache reports READY.
module tb_instruction_cache;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_cache_if bus ();

  instruction_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    bit          exp_miss;
    logic [25:0] exp_l2;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb[$];

  int          req_cnt    = 0;
  int          av_cycles  = 0;
  int          strobe_err = 0;
  logic [25:0] last_req   = '0;
  int          served     = 0;
  int          force_cnt  = 0;
  int          force_done = 0;
  logic [25:0] force_addr = '0;
  bit          l2_auto    = 1'b1;

  function automatic logic [31:0] word_of(input logic [25:0] blk, input logic [3:0] w);
    return {blk[21:0], w, 6'h2A};
  endfunction

  function automatic logic [511:0] make_block(input logic [25:0] blk);
    logic [511:0] b;
    b = '0;
    for (int w = 0; w < 16; w++) b[511-32*w -: 32] = word_of(blk, 4'(w));
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observe the L2 address channel between edges.
  always @(negedge clk) begin
    if (bus.address_to_l2_valid_instruction_cache) begin
      av_cycles++;
      if (!bus.data_from_l2_ready_instruction_cache) strobe_err++;
      if (bus.address_to_l2_ready_instruction_cache) begin
        req_cnt++;
        last_req = bus.address_to_l2_instruction_cache;
      end
    end
  end

  // L2 data channel: one-cycle fill after each accepted address, or a forced late block.
  always @(posedge clk) begin
    #1;
    if (force_cnt != force_done) begin
      force_done = force_cnt;
      bus.data_from_l2_valid_instruction_cache = 1'b1;
      bus.data_from_l2_instruction_cache       = make_block(force_addr);
    end else if (l2_auto && req_cnt != served) begin
      served = req_cnt;
      bus.data_from_l2_valid_instruction_cache = 1'b1;
      bus.data_from_l2_instruction_cache       = make_block(last_req);
    end else begin
      bus.data_from_l2_valid_instruction_cache = 1'b0;
    end
    if (!l2_auto) served = req_cnt;
  end

  task automatic wait_ready(output int waits, output bit got);
    waits = 0;
    got   = 1'b0;
    while (!got && waits < 20) begin
      if (bus.instruction_cache_ready) got = 1'b1;
      else begin
        @(negedge clk);
        waits++;
      end
    end
  endtask

  task automatic do_fetch(input vec_t v);
    int          av0, waits;
    bit          got;
    logic [31:0] exp;
    av0 = av_cycles;
    @(posedge clk); #1;
    bus.pc = v.pc;
    bus.pc_valid = 1'b1;
    bus.stall_instruction_cache = 1'b0;
    sb.push_back(word_of(v.pc[31:6], v.pc[5:2]));
    @(negedge clk);
    check("ready_same_cycle", 64'(bus.instruction_cache_ready), 64'(!v.exp_miss));
    wait_ready(waits, got);
    exp = sb.pop_front();
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_timeout: pc %0h never ready, expected word %0h", v.pc, exp);
    end else begin
      check("instruction", 64'(bus.instruction), 64'(exp));
      check("miss_latency", 64'(waits), v.exp_miss ? 64'd3 : 64'd0);
    end
    check("l2_req_cycles", 64'(av_cycles - av0), 64'(v.exp_miss));
    if (v.exp_miss) check("l2_addr", 64'(last_req), 64'(v.exp_l2));
  endtask

  vec_t vecs[14];

  initial begin
    int  waits, req0;
    bit  got;
    logic [31:0] exp;

    vecs[0]  = '{32'h0000_0008, 1'b1, 26'h0};
    vecs[1]  = '{32'h0000_0000, 1'b0, 26'h0};
    vecs[2]  = '{32'h0000_000C, 1'b0, 26'h0};
    vecs[3]  = '{32'h0000_0004, 1'b0, 26'h0};
    vecs[4]  = '{32'h0000_0010, 1'b0, 26'h0};
    vecs[5]  = '{32'h0000_0014, 1'b0, 26'h0};
    vecs[6]  = '{32'h0000_003C, 1'b0, 26'h0};
    vecs[7]  = '{32'h0000_000A, 1'b0, 26'h0};
    vecs[8]  = '{32'h0000_0040, 1'b1, 26'h1};
    vecs[9]  = '{32'h0000_0000, 1'b0, 26'h0};
    vecs[10] = '{32'h0000_1000, 1'b1, 26'h40};
    vecs[11] = '{32'h0000_0000, 1'b1, 26'h0};
    vecs[12] = '{32'h0000_1000, 1'b1, 26'h40};
    vecs[13] = '{32'h0000_0044, 1'b0, 26'h0};

    rst = 1'b1;
    bus.pc = '0;
    bus.pc_valid = 1'b0;
    bus.stall_instruction_cache = 1'b0;
    bus.address_to_l2_ready_instruction_cache = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.instruction_cache_ready), 64'd0);
    check("rst_instruction", 64'(bus.instruction), 64'd0);
    check("rst_addr_valid", 64'(bus.address_to_l2_valid_instruction_cache), 64'd0);
    check("rst_data_ready", 64'(bus.data_from_l2_ready_instruction_cache), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_fetch(vecs[i]);

    // Stall / PC_VALID gating of a miss, then a miss that completes under stall.
    @(posedge clk); #1;
    req0 = req_cnt;
    bus.pc = 32'h0000_2000;
    bus.pc_valid = 1'b1;
    bus.stall_instruction_cache = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_ready", 64'(bus.instruction_cache_ready), 64'd0);
    check("stall_no_req", 64'(bus.address_to_l2_valid_instruction_cache), 64'd0);
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    bus.stall_instruction_cache = 1'b0;
    repeat (3) @(negedge clk);
    check("pcv_low_ready", 64'(bus.instruction_cache_ready), 64'd0);
    check("gated_req_count", 64'(req_cnt - req0), 64'd0);
    @(posedge clk); #1;
    bus.pc_valid = 1'b1;
    sb.push_back(word_of(26'h80, 4'h0));
    @(negedge clk);
    check("release_idle", 64'(bus.address_to_l2_valid_instruction_cache), 64'd0);
    @(negedge clk);
    check("release_req", 64'(bus.address_to_l2_valid_instruction_cache), 64'd1);
    check("release_addr", 64'(bus.address_to_l2_instruction_cache), 64'h80);
    bus.stall_instruction_cache = 1'b1;
    wait_ready(waits, got);
    exp = sb.pop_front();
    check("stalled_fill_done", 64'(got), 64'd1);
    check("stalled_hit_word", 64'(bus.instruction), 64'(exp));
    @(posedge clk); #1;
    bus.stall_instruction_cache = 1'b0;

    // Reset while waiting for the block, then a late block that must be ignored.
    l2_auto = 1'b0;
    bus.pc = 32'h0000_3000;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.address_to_l2_valid_instruction_cache) got = 1'b1;
    end
    check("abort_req_seen", 64'(got), 64'd1);
    @(negedge clk);
    check("wait_data_ready", 64'(bus.data_from_l2_ready_instruction_cache), 64'd1);
    check("wait_addr_valid", 64'(bus.address_to_l2_valid_instruction_cache), 64'd0);
    check("wait_ready", 64'(bus.instruction_cache_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.pc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    force_addr = 26'hC0;
    force_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("late_addr_valid", 64'(bus.address_to_l2_valid_instruction_cache), 64'd0);
    check("late_data_ready", 64'(bus.data_from_l2_ready_instruction_cache), 64'd0);
    check("late_ready", 64'(bus.instruction_cache_ready), 64'd0);
    @(posedge clk); #1;
    bus.pc = 32'h0000_3000;
    bus.pc_valid = 1'b1;
    bus.stall_instruction_cache = 1'b1;
    @(negedge clk);
    check("late_block_not_hit", 64'(bus.instruction_cache_ready), 64'd0);
    l2_auto = 1'b1;
    do_fetch('{32'h0000_0008, 1'b1, 26'h0});

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("req_strobes", 64'(strobe_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
